// File: rtl/ascon_pack.sv
// Shared ASCON definitions: state layout, IV, round constants and the
// decrypt-side FSM encoding.
package ascon_pack;

  // Index 0 is the rate word S0, index 4 is S4.
  typedef logic [4:0][63:0] type_state;

  localparam logic [63:0] IV_C = 64'h80400C0600000000;

  localparam logic [3:0] ROUND_FIRST_P12 = 4'd0;
  localparam logic [3:0] ROUND_FIRST_P6  = 4'd6;
  localparam logic [3:0] ROUND_LAST      = 4'd11;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_INIT    = 3'd1,
    ST_WAIT_AD = 3'd2,
    ST_PROC_AD = 3'd3,
    ST_WAIT_C  = 3'd4,
    ST_PROC_C  = 3'd5,
    ST_FINAL   = 3'd6,
    ST_DONE    = 3'd7
  } dec_state_t;

  function automatic logic [7:0] rc(input logic [3:0] i);
    return 8'hF0 - ({4'h0, i} * 8'h0F);
  endfunction

  function automatic logic [63:0] ror64(input logic [63:0] v, input int unsigned n);
    return (v >> n) | (v << (32'd64 - n));
  endfunction

endpackage

// File: rtl/ascon_decrypt_if.sv
// Handshake and data bundle between the decrypt core and its user.
interface ascon_decrypt_if;
  logic         start_i;
  logic [127:0] key_i;
  logic [127:0] nonce_i;
  logic [127:0] tag_i;
  logic [63:0]  data_i;
  logic         data_valid_i;
  logic         data_ready_o;
  logic [63:0]  plain_o;
  logic         plain_valid_o;
  logic [127:0] tag_o;
  logic         tag_ok_o;
  logic         end_o;
  logic         busy_o;

  modport slave (
    input  start_i, key_i, nonce_i, tag_i, data_i, data_valid_i,
    output data_ready_o, plain_o, plain_valid_o, tag_o, tag_ok_o, end_o, busy_o
  );

  modport master (
    output start_i, key_i, nonce_i, tag_i, data_i, data_valid_i,
    input  data_ready_o, plain_o, plain_valid_o, tag_o, tag_ok_o, end_o, busy_o
  );
endinterface

// File: rtl/ascon_round.sv
// One combinational ASCON permutation round: constant addition, 5-bit
// S-box layer (bitsliced) and linear diffusion layer.
module ascon_round
  import ascon_pack::*;
(
  input  type_state  state,
  input  logic [7:0] rconst,
  output type_state  result
);

  logic [63:0] x0, x1, x2, x3, x4;
  logic [63:0] t0, t1, t2, t3, t4;

  always_comb begin
    x0 = state[0];
    x1 = state[1];
    x2 = state[2] ^ {56'h0, rconst};
    x3 = state[3];
    x4 = state[4];

    x0 = x0 ^ x4;
    x4 = x4 ^ x3;
    x2 = x2 ^ x1;
    t0 = ~x0 & x1;
    t1 = ~x1 & x2;
    t2 = ~x2 & x3;
    t3 = ~x3 & x4;
    t4 = ~x4 & x0;
    x0 = x0 ^ t1;
    x1 = x1 ^ t2;
    x2 = x2 ^ t3;
    x3 = x3 ^ t4;
    x4 = x4 ^ t0;
    x1 = x1 ^ x0;
    x0 = x0 ^ x4;
    x3 = x3 ^ x2;
    x2 = ~x2;

    result[0] = x0 ^ ror64(x0, 19) ^ ror64(x0, 28);
    result[1] = x1 ^ ror64(x1, 61) ^ ror64(x1, 39);
    result[2] = x2 ^ ror64(x2, 1)  ^ ror64(x2, 6);
    result[3] = x3 ^ ror64(x3, 10) ^ ror64(x3, 17);
    result[4] = x4 ^ ror64(x4, 7)  ^ ror64(x4, 41);
  end

endmodule

// File: rtl/ascon_decrypt_top.sv
// ASCON-128 decryption core: one AD block plus NB_CIPHER_BLOCKS ciphertext
// blocks, streams plaintext and checks the computed tag against tag_i.
module ascon_decrypt_top
  import ascon_pack::*;
#(
  parameter int NB_CIPHER_BLOCKS = 3
) (
  input logic            clock_i,
  input logic            reset_i,
  ascon_decrypt_if.slave bus
);

  localparam logic [3:0] LAST_BLOCK = 4'(NB_CIPHER_BLOCKS - 1);

  dec_state_t   fsm;
  type_state    s;
  type_state    s_round;
  logic [3:0]   round;
  logic [3:0]   block;
  logic [127:0] key;
  logic [127:0] tag_ref;
  logic [127:0] tag_calc;
  logic         last_round;

  logic         data_ready;
  logic [63:0]  plain;
  logic         plain_valid;
  logic [127:0] tag;
  logic         tag_ok;
  logic         end_pulse;
  logic         busy;

  ascon_round u_round (
    .state  (s),
    .rconst (rc(round)),
    .result (s_round)
  );

  assign last_round = (round == ROUND_LAST);
  assign tag_calc   = {s_round[3], s_round[4]} ^ key;

  assign bus.data_ready_o  = data_ready;
  assign bus.plain_o       = plain;
  assign bus.plain_valid_o = plain_valid;
  assign bus.tag_o         = tag;
  assign bus.tag_ok_o      = tag_ok;
  assign bus.end_o         = end_pulse;
  assign bus.busy_o        = busy;

  // Control FSM, state/counter registers and all registered outputs.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      fsm         <= ST_IDLE;
      s           <= '0;
      round       <= 4'd0;
      block       <= 4'd0;
      key         <= 128'd0;
      tag_ref     <= 128'd0;
      data_ready  <= 1'b0;
      plain       <= 64'd0;
      plain_valid <= 1'b0;
      tag         <= 128'd0;
      tag_ok      <= 1'b0;
      end_pulse   <= 1'b0;
      busy        <= 1'b0;
    end else begin
      plain_valid <= 1'b0;
      end_pulse   <= 1'b0;
      case (fsm)
        ST_IDLE: begin
          if (bus.start_i) begin
            s       <= {bus.nonce_i[63:0], bus.nonce_i[127:64],
                        bus.key_i[63:0], bus.key_i[127:64], IV_C};
            key     <= bus.key_i;
            tag_ref <= bus.tag_i;
            round   <= ROUND_FIRST_P12;
            block   <= 4'd0;
            tag     <= 128'd0;
            tag_ok  <= 1'b0;
            busy    <= 1'b1;
            fsm     <= ST_INIT;
          end
        end
        ST_INIT: begin
          s     <= s_round;
          round <= round + 4'd1;
          if (last_round) begin
            s[3]       <= s_round[3] ^ key[127:64];
            s[4]       <= s_round[4] ^ key[63:0];
            round      <= ROUND_FIRST_P6;
            data_ready <= 1'b1;
            fsm        <= ST_WAIT_AD;
          end
        end
        ST_WAIT_AD: begin
          if (bus.data_valid_i) begin
            s[0]       <= s[0] ^ bus.data_i;
            data_ready <= 1'b0;
            fsm        <= ST_PROC_AD;
          end
        end
        ST_PROC_AD: begin
          s     <= s_round;
          round <= round + 4'd1;
          if (last_round) begin
            // Domain separation between AD and ciphertext phases.
            s[4]       <= s_round[4] ^ 64'd1;
            round      <= ROUND_FIRST_P6;
            data_ready <= 1'b1;
            fsm        <= ST_WAIT_C;
          end
        end
        ST_WAIT_C: begin
          if (bus.data_valid_i) begin
            plain       <= bus.data_i ^ s[0];
            plain_valid <= 1'b1;
            s[0]        <= bus.data_i;
            block       <= block + 4'd1;
            data_ready  <= 1'b0;
            if (block == LAST_BLOCK) begin
              s[1]  <= s[1] ^ key[127:64];
              s[2]  <= s[2] ^ key[63:0];
              round <= ROUND_FIRST_P12;
              fsm   <= ST_FINAL;
            end else begin
              round <= ROUND_FIRST_P6;
              fsm   <= ST_PROC_C;
            end
          end
        end
        ST_PROC_C: begin
          s     <= s_round;
          round <= round + 4'd1;
          if (last_round) begin
            round      <= ROUND_FIRST_P6;
            data_ready <= 1'b1;
            fsm        <= ST_WAIT_C;
          end
        end
        ST_FINAL: begin
          s     <= s_round;
          round <= round + 4'd1;
          if (last_round) begin
            tag       <= tag_calc;
            tag_ok    <= (tag_calc == tag_ref);
            end_pulse <= 1'b1;
            round     <= 4'd0;
            fsm       <= ST_DONE;
          end
        end
        ST_DONE: begin
          busy <= 1'b0;
          fsm  <= ST_IDLE;
        end
        default: begin
          data_ready <= 1'b0;
          busy       <= 1'b0;
          fsm        <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
